// File: rtl/parallel_pe.sv
// LANES-wide pipelined multiply-accumulate PE: S1 multiply, S2 lane reduction, S3 accumulate.
// Optional macro PE_RELU_EN clamps negative signed results to zero on output.
module parallel_pe #(
    parameter int LANES  = 4,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LANES*DATA_W-1:0] neuron,
    input  logic [LANES*DATA_W-1:0] weight,
    input  logic [1:0]              ctl,
    input  logic                    sign_mode,
    input  logic                    vld_i,
    output logic [ACC_W-1:0]        result,
    output logic                    vld_o,
    output logic                    ovf_o
);
    localparam int PROD_W = 2 * DATA_W;

    // Operands are extended by one bit so a single signed multiplier serves both modes.
    function automatic logic [PROD_W-1:0] mul(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b,
                                              input logic              sgn);
        logic signed [PROD_W-1:0] ax;
        logic signed [PROD_W-1:0] bx;
        logic signed [PROD_W-1:0] p;
        ax = PROD_W'($signed({sgn & a[DATA_W-1], a}));
        bx = PROD_W'($signed({sgn & b[DATA_W-1], b}));
        p  = ax * bx;
        return p;
    endfunction

    // Group mode: taken from the first beat, reused by later beats of the group.
    logic have_first;
    logic held_mode;
    logic mode_in;

    always_comb begin
        mode_in = sign_mode;
        if (!ctl[0] && have_first)
            mode_in = held_mode;
    end

    // NOTE: all sequential state is written with <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            have_first <= 1'b0;
            held_mode  <= 1'b0;
        end else if (vld_i && ctl[0]) begin
            have_first <= 1'b1;
            held_mode  <= sign_mode;
        end
    end

    // S1: per-lane products
    logic              s1_vld;
    logic [1:0]        s1_ctl;
    logic              s1_mode;
    logic [PROD_W-1:0] s1_prod [LANES];

    always_ff @(posedge clk) begin
        if (rst) s1_vld <= 1'b0;
        else     s1_vld <= vld_i;
    end

    // NOTE: datapath registers carry no reset; their valid bit alone decides whether they are used.
    always_ff @(posedge clk) begin
        if (vld_i) begin
            s1_ctl  <= ctl;
            s1_mode <= mode_in;
            for (int i = 0; i < LANES; i++)
                s1_prod[i] <= mul(neuron[i*DATA_W +: DATA_W], weight[i*DATA_W +: DATA_W], mode_in);
        end
    end

    // S2: exact reduction of the lanes at full accumulator width
    logic [ACC_W-1:0] lane_sum;

    // NOTE: always_comb assigns a default before any conditional update so no latch is inferred.
    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            if (s1_mode) lane_sum = lane_sum + ACC_W'($signed(s1_prod[i]));
            else         lane_sum = lane_sum + ACC_W'(s1_prod[i]);
        end
    end

    logic             s2_vld;
    logic [1:0]       s2_ctl;
    logic             s2_mode;
    logic [ACC_W-1:0] s2_sum;

    always_ff @(posedge clk) begin
        if (rst) s2_vld <= 1'b0;
        else     s2_vld <= s1_vld;
    end

    always_ff @(posedge clk) begin
        if (s1_vld) begin
            s2_ctl  <= s1_ctl;
            s2_mode <= s1_mode;
            s2_sum  <= lane_sum;
        end
    end

    // S3: accumulate with sticky overflow
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;
    logic [ACC_W:0]   wide;
    logic             ovf_flag;
    logic             ovf_next;
    logic             step_ovf;
    logic [ACC_W-1:0] out_val;

    always_comb begin
        wide = {1'b0, acc} + {1'b0, s2_sum};
        if (s2_mode)
            step_ovf = (acc[ACC_W-1] == s2_sum[ACC_W-1]) && (wide[ACC_W-1] != acc[ACC_W-1]);
        else
            step_ovf = wide[ACC_W];
        if (s2_ctl[0]) begin
            acc_next = s2_sum;
            ovf_next = 1'b0;
        end else begin
            acc_next = wide[ACC_W-1:0];
            ovf_next = ovf_flag | step_ovf;
        end
    end

`ifdef PE_RELU_EN
    assign out_val = (s2_mode && acc_next[ACC_W-1]) ? '0 : acc_next;
`else
    assign out_val = acc_next;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            ovf_flag <= 1'b0;
            result   <= '0;
            vld_o    <= 1'b0;
            ovf_o    <= 1'b0;
        end else begin
            vld_o <= s2_vld & s2_ctl[1];
            if (s2_vld) begin
                acc      <= acc_next;
                ovf_flag <= ovf_next;
                if (s2_ctl[1]) begin
                    result <= out_val;
                    ovf_o  <= ovf_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_parallel_pe.sv
// Self-checking bench for parallel_pe: directed scenarios plus randomized beats against an
// integer reference model, on a default instance and an ACC_W=34 instance.
module tb_parallel_pe;
    localparam int LANES  = 4;
    localparam int DATA_W = 16;
    localparam int W      = LANES * DATA_W;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] neuron = '0;
    logic [W-1:0] weight = '0;
    logic [1:0]   ctl = 2'b00;
    logic         sign_mode = 1'b0;
    logic         vld_i = 1'b0;
    logic [39:0]  result0;
    logic         vld_o0, ovf_o0;
    logic [33:0]  result1;
    logic         vld_o1, ovf_o1;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int          at;
        logic [39:0] res;
        logic        ovf;
    } ev_t;

    ev_t obs0[$], obs1[$], exp0[$], exp1[$];

    // Reference model state, one copy per instance width
    longint m_acc [2];
    bit     m_ovf [2];
    bit     m_have [2];
    bit     m_held [2];
    int     aw [2] = '{40, 34};

    parallel_pe #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(40)) dut0 (
        .clk(clk), .rst(rst), .neuron(neuron), .weight(weight), .ctl(ctl),
        .sign_mode(sign_mode), .vld_i(vld_i), .result(result0), .vld_o(vld_o0), .ovf_o(ovf_o0)
    );

    parallel_pe #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(34)) dut1 (
        .clk(clk), .rst(rst), .neuron(neuron), .weight(weight), .ctl(ctl),
        .sign_mode(sign_mode), .vld_i(vld_i), .result(result1), .vld_o(vld_o1), .ovf_o(ovf_o1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (vld_o0) obs0.push_back('{at: cyc, res: result0, ovf: ovf_o0});
        if (vld_o1) obs1.push_back('{at: cyc, res: 40'(result1), ovf: ovf_o1});
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got running want finished");
        $fatal(1);
    end

    function automatic logic [W-1:0] pack4(input logic [15:0] a, input logic [15:0] b,
                                           input logic [15:0] c, input logic [15:0] d);
        return {d, c, b, a};
    endfunction

    function automatic logic [W-1:0] rep4(input logic [15:0] a);
        return {a, a, a, a};
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_acc[k] = 0; m_ovf[k] = 0; m_have[k] = 0; m_held[k] = 0;
        end
    endfunction

    // Dot product as plain integers; overflow judged by range of the exact sum
    function automatic void model_beat(input logic [W-1:0] n, input logic [W-1:0] w,
                                       input logic [1:0] c, input logic sm);
        for (int k = 0; k < 2; k++) begin
            longint full, half, s, base, tot, nxt, val, a, b;
            bit mode, ov;
            full = longint'(1) << aw[k];
            half = full >> 1;
            mode = c[0] ? sm : (m_have[k] ? m_held[k] : sm);
            s = 0;
            for (int i = 0; i < LANES; i++) begin
                if (mode) begin
                    a = longint'($signed(n[i*DATA_W +: DATA_W]));
                    b = longint'($signed(w[i*DATA_W +: DATA_W]));
                end else begin
                    a = longint'(n[i*DATA_W +: DATA_W]);
                    b = longint'(w[i*DATA_W +: DATA_W]);
                end
                s += a * b;
            end
            if (c[0]) begin
                tot = s;
                ov = 0;
                m_have[k] = 1;
                m_held[k] = sm;
            end else begin
                base = (mode && m_acc[k] >= half) ? m_acc[k] - full : m_acc[k];
                tot = base + s;
                ov = m_ovf[k] || (mode ? (tot < -half || tot >= half) : (tot >= full));
            end
            nxt = ((tot % full) + full) % full;
            m_acc[k] = nxt;
            m_ovf[k] = ov;
            if (c[1]) begin
                val = nxt;
`ifdef PE_RELU_EN
                if (mode && nxt >= half) val = 0;
`endif
                if (k == 0) exp0.push_back('{at: cyc + 3, res: 40'(val), ovf: ov});
                else        exp1.push_back('{at: cyc + 3, res: 40'(val), ovf: ov});
            end
        end
    endfunction

    task automatic beat(input logic [W-1:0] n, input logic [W-1:0] w, input logic [1:0] c,
                        input logic sm, input logic v);
        neuron = n; weight = w; ctl = c; sign_mode = sm; vld_i = v;
        if (v) model_beat(n, w, c, sm);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        vld_i = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; vld_i = 1'b1; ctl = 2'b11; neuron = '1; weight = '1;
        repeat (3) @(negedge clk);
        n_cmp++; if (vld_o0 !== 1'b0) begin n_bad++; $display("FAIL reset_vld_o: got %b want 0", vld_o0); end
        n_cmp++; if (result0 !== 40'd0) begin n_bad++; $display("FAIL reset_result: got %0h want 0", result0); end
        n_cmp++; if (ovf_o0 !== 1'b0) begin n_bad++; $display("FAIL reset_ovf_o: got %b want 0", ovf_o0); end
        rst = 1'b0; vld_i = 1'b0; ctl = 2'b00;
        model_reset();
        obs0.delete(); obs1.delete();
        idle(6);
        n_cmp++; if (obs0.size() != 0) begin n_bad++; $display("FAIL reset_no_output: got %0d pulses want 0", obs0.size()); end
    endtask

    task automatic test_single();
        int t;
        obs0.delete();
        t = cyc;
        beat(pack4(16'd1, 16'd2, 16'd3, 16'd4), pack4(16'd5, 16'd6, 16'd7, 16'd8), 2'b11, 1'b1, 1'b1);
        idle(6);
        n_cmp++; if (obs0.size() != 1) begin n_bad++; $display("FAIL single_count: got %0d want 1", obs0.size()); end
        if (obs0.size() > 0) begin
            n_cmp++; if (obs0[0].at != t + 3) begin n_bad++; $display("FAIL single_latency: got cycle %0d want %0d", obs0[0].at, t + 3); end
            n_cmp++; if (obs0[0].res !== 40'd70) begin n_bad++; $display("FAIL single_result: got %0d want 70", obs0[0].res); end
            n_cmp++; if (obs0[0].ovf !== 1'b0) begin n_bad++; $display("FAIL single_ovf: got %b want 0", obs0[0].ovf); end
        end
    endtask

    task automatic test_long();
        int t;
        obs0.delete();
        t = 0;
        for (int b = 0; b < 32; b++) begin
            if (b == 31) t = cyc;
            beat(rep4(16'h0001), rep4(16'h0002), {b == 31, b == 0}, 1'b0, 1'b1);
        end
        idle(6);
        n_cmp++; if (obs0.size() != 1) begin n_bad++; $display("FAIL long_count: got %0d want 1", obs0.size()); end
        if (obs0.size() > 0) begin
            n_cmp++; if (obs0[0].res !== 40'd256) begin n_bad++; $display("FAIL long_result: got %0d want 256", obs0[0].res); end
            n_cmp++; if (obs0[0].at != t + 3) begin n_bad++; $display("FAIL long_latency: got cycle %0d want %0d", obs0[0].at, t + 3); end
        end
    endtask

    task automatic test_ffff();
        logic [39:0] want_signed;
`ifdef PE_RELU_EN
        want_signed = 40'd0;
`else
        want_signed = 40'hFF_FFFF_FFE8;
`endif
        obs0.delete();
        beat(rep4(16'hFFFF), rep4(16'h0003), 2'b01, 1'b1, 1'b1);
        beat(rep4(16'hFFFF), rep4(16'h0003), 2'b10, 1'b0, 1'b1);
        beat(rep4(16'hFFFF), rep4(16'h0003), 2'b01, 1'b0, 1'b1);
        beat(rep4(16'hFFFF), rep4(16'h0003), 2'b10, 1'b1, 1'b1);
        idle(6);
        n_cmp++; if (obs0.size() != 2) begin n_bad++; $display("FAIL ffff_count: got %0d want 2", obs0.size()); end
        if (obs0.size() > 1) begin
            n_cmp++; if (obs0[0].res !== want_signed) begin n_bad++; $display("FAIL ffff_signed: got %0h want %0h", obs0[0].res, want_signed); end
            n_cmp++; if (obs0[1].res !== 40'd1572840) begin n_bad++; $display("FAIL ffff_unsigned: got %0d want 1572840", obs0[1].res); end
            n_cmp++; if (obs0[0].ovf !== 1'b0 || obs0[1].ovf !== 1'b0) begin n_bad++; $display("FAIL ffff_ovf: got %b%b want 00", obs0[0].ovf, obs0[1].ovf); end
        end
    endtask

    task automatic test_bubbles_reset();
        obs0.delete();
        for (int b = 0; b < 10; b++) begin
            if ($urandom_range(0, 2) == 0) idle(1);
            beat(rep4(16'h0001), rep4(16'h0002), {1'b0, b == 0}, 1'b0, 1'b1);
        end
        rst = 1'b1; vld_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int b = 0; b < 32; b++) begin
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
            beat(rep4(16'h0001), rep4(16'h0002), {b == 31, b == 0}, 1'b0, 1'b1);
        end
        idle(6);
        n_cmp++; if (obs0.size() != 1) begin n_bad++; $display("FAIL bubbles_count: got %0d want 1", obs0.size()); end
        if (obs0.size() > 0) begin
            n_cmp++; if (obs0[0].res !== 40'd256) begin n_bad++; $display("FAIL bubbles_result: got %0d want 256", obs0[0].res); end
        end
    endtask

    task automatic test_back_to_back();
        int t;
        obs0.delete();
        t = cyc;
        beat(rep4(16'd1), rep4(16'd2), 2'b11, 1'b0, 1'b1);
        beat(pack4(16'd3, 16'd0, 16'd0, 16'd0), pack4(16'd3, 16'd0, 16'd0, 16'd0), 2'b11, 1'b0, 1'b1);
        idle(6);
        n_cmp++; if (obs0.size() != 2) begin n_bad++; $display("FAIL b2b_count: got %0d want 2", obs0.size()); end
        if (obs0.size() > 1) begin
            n_cmp++; if (obs0[0].res !== 40'd8) begin n_bad++; $display("FAIL b2b_first: got %0d want 8", obs0[0].res); end
            n_cmp++; if (obs0[1].res !== 40'd9) begin n_bad++; $display("FAIL b2b_second: got %0d want 9", obs0[1].res); end
            n_cmp++; if (obs0[0].at != t + 3 || obs0[1].at != t + 4) begin n_bad++; $display("FAIL b2b_timing: got %0d,%0d want %0d,%0d", obs0[0].at, obs0[1].at, t + 3, t + 4); end
        end
    endtask

    task automatic test_ovf34();
        obs0.delete(); obs1.delete();
        beat(rep4(16'hFFFF), rep4(16'hFFFF), 2'b01, 1'b0, 1'b1);
        beat(rep4(16'hFFFF), rep4(16'hFFFF), 2'b10, 1'b0, 1'b1);
        beat(rep4(16'd1), rep4(16'd1), 2'b11, 1'b0, 1'b1);
        idle(6);
        n_cmp++; if (obs1.size() != 2) begin n_bad++; $display("FAIL ovf34_count: got %0d want 2", obs1.size()); end
        if (obs1.size() > 1) begin
            n_cmp++; if (obs1[0].res !== 40'h3_FFF0_0008) begin n_bad++; $display("FAIL ovf34_result: got %0h want 3fff00008", obs1[0].res); end
            n_cmp++; if (obs1[0].ovf !== 1'b1) begin n_bad++; $display("FAIL ovf34_flag: got %b want 1", obs1[0].ovf); end
            n_cmp++; if (obs1[1].ovf !== 1'b0) begin n_bad++; $display("FAIL ovf34_cleared: got %b want 0", obs1[1].ovf); end
            n_cmp++; if (obs1[1].res !== 40'd4) begin n_bad++; $display("FAIL ovf34_next: got %0d want 4", obs1[1].res); end
        end
        if (obs0.size() > 0) begin
            n_cmp++; if (obs0[0].res !== 40'h7_FFF0_0008 || obs0[0].ovf !== 1'b0) begin n_bad++; $display("FAIL ovf40_wide: got %0h/%b want 7fff00008/0", obs0[0].res, obs0[0].ovf); end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] n, w;
        logic [1:0]   c;
        rst = 1'b1; vld_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        obs0.delete(); obs1.delete(); exp0.delete(); exp1.delete();
        beat({$urandom(), $urandom()}, {$urandom(), $urandom()}, 2'b00, 1'($urandom_range(0, 1)), 1'b1);
        for (int b = 0; b < 600; b++) begin
            n = {$urandom(), $urandom()};
            w = {$urandom(), $urandom()};
            if ($urandom_range(0, 1) == 0) begin
                n = n & rep4(16'h00FF);
                w = w & rep4(16'h00FF);
            end
            c[0] = ($urandom_range(0, 3) == 0);
            c[1] = ($urandom_range(0, 3) == 0);
            beat(n, w, c, 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
        end
        beat(rep4(16'd7), rep4(16'd9), 2'b10, 1'b0, 1'b1);
        idle(6);
        n_cmp++; if (obs0.size() != exp0.size()) begin n_bad++; $display("FAIL rand40_count: got %0d want %0d", obs0.size(), exp0.size()); end
        for (int i = 0; i < exp0.size() && i < obs0.size(); i++) begin
            n_cmp++;
            if (obs0[i].at != exp0[i].at || obs0[i].res !== exp0[i].res || obs0[i].ovf !== exp0[i].ovf) begin
                n_bad++;
                $display("FAIL rand40_evt%0d: got t=%0d r=%0h o=%b want t=%0d r=%0h o=%b", i,
                         obs0[i].at, obs0[i].res, obs0[i].ovf, exp0[i].at, exp0[i].res, exp0[i].ovf);
            end
        end
        n_cmp++; if (obs1.size() != exp1.size()) begin n_bad++; $display("FAIL rand34_count: got %0d want %0d", obs1.size(), exp1.size()); end
        for (int i = 0; i < exp1.size() && i < obs1.size(); i++) begin
            n_cmp++;
            if (obs1[i].at != exp1[i].at || obs1[i].res !== exp1[i].res || obs1[i].ovf !== exp1[i].ovf) begin
                n_bad++;
                $display("FAIL rand34_evt%0d: got t=%0d r=%0h o=%b want t=%0d r=%0h o=%b", i,
                         obs1[i].at, obs1[i].res, obs1[i].ovf, exp1[i].at, exp1[i].res, exp1[i].ovf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_long();
        test_ffff();
        test_bubbles_reset();
        test_back_to_back();
        test_ovf34();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/parallel_pe.md
Name: parallel_pe

Overview:
Multi-lane successor to serial_pe: a pipelined LANES-wide multiply-accumulate PE for neuron·weight dot products. Each valid beat multiplies LANES neuron/weight pairs, reduces them with an adder tree, and accumulates across beats framed by first/last control. Supports signed or unsigned operands and reports accumulator overflow. It sits where serial_pe sits, fed by the neuron/weight line fetch logic, and raises LANES× the throughput.

Parameters:
LANES, 4, number of parallel multiply lanes (power of 2, ≥1)
DATA_W, 16, width of each neuron/weight element
ACC_W, 40, accumulator/result width; must be ≥ 2*DATA_W + clog2(LANES)

Ports:
clk  in  1  clock
rst  in  1  reset
neuron  in  LANES*DATA_W  lane i = bits [i*DATA_W +: DATA_W], lane 0 at LSB
weight  in  LANES*DATA_W  same packing as neuron
ctl  in  2  ctl[0]=first beat of accumulation, ctl[1]=last beat
sign_mode  in  1  1=signed two's-complement operands, 0=unsigned
vld_i  in  1  input beat valid
result  out  ACC_W  accumulated dot product
vld_o  out  1  one-cycle pulse, result/ovf_o valid
ovf_o  out  1  accumulation overflowed (valid with vld_o)

Interface: one clock; reset is synchronous and active-high.

Behaviour:
- Reset: result=0, vld_o=0, ovf_o=0. All pipeline valids, the accumulator, the held mode and the sticky overflow clear. Reset mid-accumulation discards the partial sum; no vld_o for that group.
- No backpressure. Every vld_i=1 beat is consumed. ctl and sign_mode are ignored when vld_i=0. Bubbles hold all accumulation state.
- S1 (registered): p[i] = neuron[i] × weight[i], 2*DATA_W bits, signed or unsigned per the effective mode.
- S2 (registered): sum = Σ p[i], extended (sign- or zero-, per mode) to ACC_W. Exact, no loss.
- S3: acc_next = first ? sum : acc + sum, modulo 2^ACC_W. acc updates only on valid S3 beats.
- ctl, mode and valid travel with data through S1–S3.
- Latency: vld_i with ctl[1]=1 at cycle T gives vld_o=1 at T+3, with result=acc_next and ovf_o.
- result and ovf_o hold their values until the next vld_o.
- Mode: sign_mode is sampled on the first beat and applies to the whole group. It is ignored on non-first beats.
- Overflow: sticky flag. It is set on the first beat to 0. On a non-first beat it is set if acc+sum overflows: signed overflow in signed mode, carry-out in unsigned mode. ovf_o = the flag including the last beat.
- first & last on the same beat: result = that beat's sum, ovf_o=0.
- Non-first beat with no preceding first since reset: accumulates onto acc=0 with the mode of that beat.
- last of one group followed immediately by first of the next: back-to-back vld_o pulses, no interference.
- A first beat mid-group abandons the running sum; no vld_o for the abandoned part.
- Back-to-back throughput: 1 beat/cycle.

Optional Feature:
PE_RELU_EN
- Defined: on vld_o, if the effective mode is signed and acc_next is negative, result=0. ovf_o is unaffected. Unsigned mode is unaffected.
- Undefined: result is always the raw acc_next.

Test Plan:
1. Signed, first+last single beat, neuron lanes {1,2,3,4}, weight {5,6,7,8} -> vld_o at T+3, result=70, ovf_o=0.
2. 32 beats, all lanes 16'h0001×16'h0002, first on beat 0, last on beat 31 -> exactly one vld_o, result=256.
3. neuron all lanes 16'hFFFF, weight 16'h0003, 2 beats:
   - signed -> result=40'hFF_FFFF_FFE8 (−24)
   - unsigned -> result=1572840
   - with PE_RELU_EN, signed -> result=0
4. Test-2 stream with random vld_i=0 bubbles, plus a rst pulse inside an earlier group -> aborted group gives no vld_o; later group gives result=256.
5. Group A (1 beat, {1,1,1,1}·{2,2,2,2}) immediately followed by group B (1 beat, {3,0,0,0}·{3,0,0,0}) -> vld_o on two consecutive cycles, result=8 then 9.
6. ACC_W=34 instance, unsigned, all lanes 16'hFFFF×16'hFFFF, 2 beats -> result=34'h3_FFF0_0008, ovf_o=1. Next single-beat group -> ovf_o=0.
